// File: rtl/decoder_host_link_pkg.sv
// Shared constants and sizing helpers so the decoding controller and its host link agree
// on the byte protocol and on the per-round framing widths.
package decoder_host_link_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h02;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h01;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HDR,
    TX_WAIT_MEAS,
    TX_BYTES
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_ITER,
    RX_CYC_HI,
    RX_CYC_LO,
    RX_CORR
  } rx_field_t;

  function automatic int bytes_per_round(input int grid_x, input int grid_z);
    return (grid_x * grid_z + 7) >> 3;
  endfunction

  function automatic int correction_count_per_round(input int grid_x, input int grid_z);
    return 2 * (grid_x - 1) * grid_z + 1 + grid_x * grid_z;
  endfunction

  function automatic int corr_bytes(input int grid_x, input int grid_z);
    return (correction_count_per_round(grid_x, grid_z) + 7) >> 3;
  endfunction

endpackage

// File: rtl/decoder_host_link_result_deserializer.sv
// Parses the controller's result byte stream into iteration/cycle statistics and
// per-round correction words, with a valid/ready handshake on the correction output.
module decoder_host_link_result_deserializer
  import decoder_host_link_pkg::*;
#(
  parameter int CORR_COUNT = 11,
  parameter int CORR_BYTES = 2,
  parameter int ROUNDS     = 2,
  parameter int ROUND_W    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  busy,
  input  logic [7:0]            dec_out_data,
  input  logic                  dec_out_valid,
  output logic                  dec_out_ready,
  output logic [CORR_COUNT-1:0] corr_data,
  output logic [ROUND_W-1:0]    corr_round,
  output logic                  corr_valid,
  input  logic                  corr_ready,
  output logic [7:0]            iteration_count,
  output logic [15:0]           cycle_count,
  output logic                  stats_valid,
  output logic                  frame_error,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(3 + ROUNDS * CORR_BYTES);
  localparam int BI_W  = (CORR_BYTES > 1) ? $clog2(CORR_BYTES) : 1;

  logic [CNT_W-1:0]        rx_cnt;
  logic [BI_W-1:0]         byte_idx;
  logic [ROUND_W-1:0]      rx_round;
  logic [CORR_BYTES*8-1:0] asm_q;
  logic [CORR_BYTES*8-1:0] asm_n;
  rx_field_t               field;
  logic                    byte_acc;
  logic                    corr_acc;

  // Holding off result bytes while a word is pending guarantees nothing is overwritten.
  assign dec_out_ready = !corr_valid;
  assign byte_acc      = dec_out_valid && !corr_valid;
  assign corr_acc      = corr_valid && corr_ready;
  assign frame_done    = corr_acc && (corr_round == ROUND_W'(ROUNDS - 1));

  always_comb begin
    field = RX_CORR;
    if (rx_cnt == CNT_W'(0))      field = RX_ITER;
    else if (rx_cnt == CNT_W'(1)) field = RX_CYC_HI;
    else if (rx_cnt == CNT_W'(2)) field = RX_CYC_LO;
    asm_n = asm_q;
    asm_n[8*byte_idx +: 8] = dec_out_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt          <= '0;
      byte_idx        <= '0;
      rx_round        <= '0;
      asm_q           <= '0;
      corr_data       <= '0;
      corr_round      <= '0;
      corr_valid      <= 1'b0;
      iteration_count <= '0;
      cycle_count     <= '0;
      stats_valid     <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      stats_valid <= frame_done;
      frame_error <= byte_acc && !busy;
      if (corr_acc) corr_valid <= 1'b0;
      if (frame_done) begin
        rx_cnt   <= '0;
        byte_idx <= '0;
        rx_round <= '0;
      end
      if (byte_acc && busy) begin
        rx_cnt <= rx_cnt + 1'b1;
        unique case (field)
          RX_ITER:   iteration_count   <= dec_out_data;
          RX_CYC_HI: cycle_count[15:8] <= dec_out_data;
          RX_CYC_LO: cycle_count[7:0]  <= dec_out_data;
          default: begin
            asm_q <= asm_n;
            if (byte_idx == BI_W'(CORR_BYTES - 1)) begin
              corr_data  <= CORR_COUNT'(asm_n);
              corr_valid <= 1'b1;
              corr_round <= rx_round;
              byte_idx   <= '0;
              rx_round   <= rx_round + 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/decoder_host_link.sv
// Host-side link to the decoding controller: frames measurement rounds into its input
// byte stream and hands the result stream to the deserializer.
module decoder_host_link
  import decoder_host_link_pkg::*;
#(
  parameter  int GRID_WIDTH_X = 4,
  parameter  int GRID_WIDTH_Z = 1,
  parameter  int GRID_WIDTH_U = 5,
  localparam int ROUNDS                     = GRID_WIDTH_U / 2,
  localparam int BYTES_PER_ROUND            = bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z),
  localparam int ALIGNED_PU_PER_ROUND       = BYTES_PER_ROUND * 8,
  localparam int CORRECTION_COUNT_PER_ROUND = correction_count_per_round(GRID_WIDTH_X, GRID_WIDTH_Z),
  localparam int CORR_BYTES                 = corr_bytes(GRID_WIDTH_X, GRID_WIDTH_Z),
  localparam int ROUND_W                    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_valid,
  input  logic                                  start_cmd,
  output logic                                  start_ready,
  input  logic [ALIGNED_PU_PER_ROUND-1:0]       meas_data,
  input  logic                                  meas_valid,
  output logic                                  meas_ready,
  output logic [7:0]                            dec_in_data,
  output logic                                  dec_in_valid,
  input  logic                                  dec_in_ready,
  input  logic [7:0]                            dec_out_data,
  input  logic                                  dec_out_valid,
  output logic                                  dec_out_ready,
  output logic [CORRECTION_COUNT_PER_ROUND-1:0] corr_data,
  output logic [ROUND_W-1:0]                    corr_round,
  output logic                                  corr_valid,
  input  logic                                  corr_ready,
  output logic [7:0]                            iteration_count,
  output logic [15:0]                           cycle_count,
  output logic                                  stats_valid,
  output logic                                  busy,
  output logic                                  frame_error
);

  localparam int BYTE_IDX_W = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;

  tx_state_t                       tx_state, tx_state_n;
  logic [7:0]                      in_data_n;
  logic                            in_valid_n;
  logic                            is_param, is_param_n;
  logic [ALIGNED_PU_PER_ROUND-1:0] shreg, shreg_n;
  logic [BYTE_IDX_W-1:0]           byte_idx, byte_idx_n;
  logic [ROUND_W-1:0]              tx_round, tx_round_n;
  logic                            busy_n;
  logic                            frame_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      dec_in_data  <= '0;
      dec_in_valid <= 1'b0;
      is_param     <= 1'b0;
      shreg        <= '0;
      byte_idx     <= '0;
      tx_round     <= '0;
      busy         <= 1'b0;
    end else begin
      tx_state     <= tx_state_n;
      dec_in_data  <= in_data_n;
      dec_in_valid <= in_valid_n;
      is_param     <= is_param_n;
      shreg        <= shreg_n;
      byte_idx     <= byte_idx_n;
      tx_round     <= tx_round_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    tx_state_n  = tx_state;
    in_data_n   = dec_in_data;
    in_valid_n  = dec_in_valid;
    is_param_n  = is_param;
    shreg_n     = shreg;
    byte_idx_n  = byte_idx;
    tx_round_n  = tx_round;
    busy_n      = busy;
    start_ready = 1'b0;
    meas_ready  = 1'b0;
    if (frame_done) busy_n = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        start_ready = !busy;
        if (start_valid && !busy) begin
          is_param_n = start_cmd;
          in_data_n  = start_cmd ? START_DECODING_MSG : MEASUREMENT_DATA_HEADER;
          in_valid_n = 1'b1;
          if (!start_cmd) busy_n = 1'b1;
          tx_state_n = TX_HDR;
        end
      end
      TX_HDR: begin
        if (dec_in_ready) begin
          in_valid_n = 1'b0;
          tx_round_n = '0;
          tx_state_n = is_param ? TX_IDLE : TX_WAIT_MEAS;
        end
      end
      TX_WAIT_MEAS: begin
        meas_ready = 1'b1;
        if (meas_valid) begin
          // Byte 0 goes straight to the output register; the rest queue LSB-first.
          in_data_n  = meas_data[7:0];
          in_valid_n = 1'b1;
          shreg_n    = meas_data >> 8;
          byte_idx_n = '0;
          tx_state_n = TX_BYTES;
        end
      end
      TX_BYTES: begin
        if (dec_in_ready) begin
          if (byte_idx == BYTE_IDX_W'(BYTES_PER_ROUND - 1)) begin
            in_valid_n = 1'b0;
            if (tx_round == ROUND_W'(ROUNDS - 1)) begin
              tx_state_n = TX_IDLE;
            end else begin
              tx_round_n = tx_round + 1'b1;
              tx_state_n = TX_WAIT_MEAS;
            end
          end else begin
            in_data_n  = shreg[7:0];
            shreg_n    = shreg >> 8;
            byte_idx_n = byte_idx + 1'b1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  decoder_host_link_result_deserializer #(
    .CORR_COUNT (CORRECTION_COUNT_PER_ROUND),
    .CORR_BYTES (CORR_BYTES),
    .ROUNDS     (ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_result_deserializer (
    .clk             (clk),
    .reset           (reset),
    .busy            (busy),
    .dec_out_data    (dec_out_data),
    .dec_out_valid   (dec_out_valid),
    .dec_out_ready   (dec_out_ready),
    .corr_data       (corr_data),
    .corr_round      (corr_round),
    .corr_valid      (corr_valid),
    .corr_ready      (corr_ready),
    .iteration_count (iteration_count),
    .cycle_count     (cycle_count),
    .stats_valid     (stats_valid),
    .frame_error     (frame_error),
    .frame_done      (frame_done)
  );

endmodule

// File: tb/tb_decoder_host_link.sv
// Directed bench for decoder_host_link: table-driven full frames plus hand-written
// sequences for parameter load, backpressure, correction stalls, idle bytes and reset.
module tb_decoder_host_link;
  import decoder_host_link_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_cmd = 1'b0;
  logic        start_ready;
  logic [7:0]  meas_data = '0;
  logic        meas_valid = 1'b0;
  logic        meas_ready;
  logic [7:0]  dec_in_data;
  logic        dec_in_valid;
  logic        dec_in_ready = 1'b1;
  logic [7:0]  dec_out_data = '0;
  logic        dec_out_valid = 1'b0;
  logic        dec_out_ready;
  logic [10:0] corr_data;
  logic [0:0]  corr_round;
  logic        corr_valid;
  logic        corr_ready = 1'b1;
  logic [7:0]  iteration_count;
  logic [15:0] cycle_count;
  logic        stats_valid;
  logic        busy;
  logic        frame_error;

  decoder_host_link #(
    .GRID_WIDTH_X (4),
    .GRID_WIDTH_Z (1),
    .GRID_WIDTH_U (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_valid     (start_valid),
    .start_cmd       (start_cmd),
    .start_ready     (start_ready),
    .meas_data       (meas_data),
    .meas_valid      (meas_valid),
    .meas_ready      (meas_ready),
    .dec_in_data     (dec_in_data),
    .dec_in_valid    (dec_in_valid),
    .dec_in_ready    (dec_in_ready),
    .dec_out_data    (dec_out_data),
    .dec_out_valid   (dec_out_valid),
    .dec_out_ready   (dec_out_ready),
    .corr_data       (corr_data),
    .corr_round      (corr_round),
    .corr_valid      (corr_valid),
    .corr_ready      (corr_ready),
    .iteration_count (iteration_count),
    .cycle_count     (cycle_count),
    .stats_valid     (stats_valid),
    .busy            (busy),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       m0;
    logic [7:0]       m1;
    logic [0:6][7:0]  rx;
    logic [7:0]       iter;
    logic [15:0]      cyc;
    logic [10:0]      c0;
    logic [10:0]      c1;
  } frame_t;

  frame_t frames[3];

  int errors = 0;
  int checks = 0;
  int n_stats = 0;
  int n_ferr = 0;
  logic [15:0] tx_q[$];
  logic [15:0] corr_q[$];
  logic [15:0] cr_q[$];

  // Transfer monitor: samples just after the falling edge, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (dec_in_valid && dec_in_ready) tx_q.push_back(16'(dec_in_data));
      if (corr_valid && corr_ready) begin
        corr_q.push_back(16'(corr_data));
        cr_q.push_back(16'(corr_round));
      end
      if (stats_valid) n_stats++;
      if (frame_error) n_ferr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [15:0] q[$], input int i);
    if (i < q.size()) return 32'(q[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_qs();
    tx_q.delete();
    corr_q.delete();
    cr_q.delete();
  endtask

  task automatic do_start(input logic cmd);
    bit ok = 0;
    start_cmd = cmd;
    start_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      ok = start_ready;
      @(negedge clk);
    end
    start_valid = 1'b0;
    if (!ok) check("start timeout", 0, 1);
  endtask

  task automatic put_meas(input logic [7:0] w);
    bit ok = 0;
    meas_data = w;
    meas_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      ok = meas_ready;
      @(negedge clk);
    end
    meas_valid = 1'b0;
    if (!ok) check("meas timeout", 0, 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bit ok = 0;
    dec_out_data = b;
    dec_out_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      ok = dec_out_ready;
      @(negedge clk);
    end
    dec_out_valid = 1'b0;
    if (!ok) check("rx timeout", 0, 1);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 100 && tx_q.size() < n; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input frame_t f, input string tag, input int s0, input int e0);
    check({tag, " tx count"}, tx_q.size(), 3);
    check({tag, " tx hdr"}, qget(tx_q, 0), 32'(MEASUREMENT_DATA_HEADER));
    check({tag, " tx byte0"}, qget(tx_q, 1), 32'(f.m0));
    check({tag, " tx byte1"}, qget(tx_q, 2), 32'(f.m1));
    check({tag, " iteration_count"}, 32'(iteration_count), 32'(f.iter));
    check({tag, " cycle_count"}, 32'(cycle_count), 32'(f.cyc));
    check({tag, " corr count"}, corr_q.size(), 2);
    check({tag, " corr0"}, qget(corr_q, 0), 32'(f.c0));
    check({tag, " round0"}, qget(cr_q, 0), 0);
    check({tag, " corr1"}, qget(corr_q, 1), 32'(f.c1));
    check({tag, " round1"}, qget(cr_q, 1), 1);
    check({tag, " stats pulses"}, n_stats - s0, 1);
    check({tag, " frame_error pulses"}, n_ferr - e0, 0);
    check({tag, " busy after"}, 32'(busy), 0);
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    int s0;
    int e0;
    clear_qs();
    s0 = n_stats;
    e0 = n_ferr;
    do_start(1'b0);
    put_meas(f.m0);
    put_meas(f.m1);
    wait_tx(3);
    for (int i = 0; i < 7; i++) send_rx(f.rx[i]);
    idle(6);
    check_frame(f, tag, s0, e0);
  endtask

  initial begin
    int s0;
    int e0;
    int bad;

    frames[0] = '{m0: 8'h5A, m1: 8'h03,
                  rx: {8'h04, 8'h01, 8'h2C, 8'h34, 8'h05, 8'hFF, 8'h07},
                  iter: 8'h04, cyc: 16'h012C, c0: 11'h534, c1: 11'h7FF};
    frames[1] = '{m0: 8'hA5, m1: 8'hFF,
                  rx: {8'h9A, 8'h00, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'hF8},
                  iter: 8'h9A, cyc: 16'h0007, c0: 11'h7FF, c1: 11'h000};
    frames[2] = '{m0: 8'h00, m1: 8'h80,
                  rx: {8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h55, 8'h02},
                  iter: 8'hFF, cyc: 16'hFFFF, c0: 11'h001, c1: 11'h255};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst dec_in_valid", 32'(dec_in_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst corr_valid", 32'(corr_valid), 0);
    check("rst iteration_count", 32'(iteration_count), 0);
    check("rst cycle_count", 32'(cycle_count), 0);
    check("rst start_ready", 32'(start_ready), 1);
    check("rst dec_out_ready", 32'(dec_out_ready), 1);
    check("rst meas_ready", 32'(meas_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 3; i++) run_frame(frames[i], $sformatf("frame%0d", i));

    // Parameter load
    clear_qs();
    do_start(1'b1);
    #1;
    check("pl busy", 32'(busy), 0);
    check("pl start_ready while pending", 32'(start_ready), 0);
    @(negedge clk);
    #1;
    check("pl start_ready after", 32'(start_ready), 1);
    check("pl busy after", 32'(busy), 0);
    check("pl tx count", tx_q.size(), 1);
    check("pl tx byte", qget(tx_q, 0), 32'(START_DECODING_MSG));
    @(negedge clk);
    idle(3);
    check("pl no extra bytes", tx_q.size(), 1);

    // dec_in backpressure while 0x5A is pending
    clear_qs();
    s0 = n_stats;
    e0 = n_ferr;
    do_start(1'b0);
    put_meas(frames[0].m0);
    dec_in_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!(dec_in_valid && dec_in_data == 8'h5A)) bad++;
      @(negedge clk);
    end
    check("bp byte held", bad, 0);
    dec_in_ready = 1'b1;
    put_meas(frames[0].m1);
    wait_tx(3);
    for (int i = 0; i < 7; i++) send_rx(frames[0].rx[i]);
    idle(6);
    check_frame(frames[0], "bp", s0, e0);

    // corr_ready stall after round 0
    clear_qs();
    s0 = n_stats;
    e0 = n_ferr;
    do_start(1'b0);
    put_meas(frames[0].m0);
    put_meas(frames[0].m1);
    wait_tx(3);
    corr_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rx(frames[0].rx[i]);
    dec_out_data = frames[0].rx[5];
    dec_out_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (dec_out_ready || !corr_valid) bad++;
      @(negedge clk);
    end
    check("stall dec_out_ready low", bad, 0);
    check("stall no corr transfer", corr_q.size(), 0);
    corr_ready = 1'b1;
    send_rx(frames[0].rx[5]);
    send_rx(frames[0].rx[6]);
    idle(6);
    check_frame(frames[0], "stall", s0, e0);

    // Result bytes while idle
    clear_qs();
    s0 = n_stats;
    e0 = n_ferr;
    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h33);
    idle(4);
    check("idle frame_error pulses", n_ferr - e0, 3);
    check("idle corr count", corr_q.size(), 0);
    check("idle stats pulses", n_stats - s0, 0);
    check("idle iteration_count kept", 32'(iteration_count), 32'(frames[0].iter));

    // Asynchronous reset after the header byte
    clear_qs();
    s0 = n_stats;
    do_start(1'b0);
    @(negedge clk);
    #1;
    check("mid busy", 32'(busy), 1);
    #1;
    reset = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 0);
    check("async rst dec_in_valid", 32'(dec_in_valid), 0);
    check("async rst iteration_count", 32'(iteration_count), 0);
    check("async rst cycle_count", 32'(cycle_count), 0);
    check("async rst meas_ready", 32'(meas_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post rst start_ready", 32'(start_ready), 1);
    check("post rst no stats", n_stats - s0, 0);
    check("post rst no corr", corr_q.size(), 0);
    @(negedge clk);
    run_frame(frames[0], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
